// File: rtl/particle_feeder_pkg.sv
// Shared particle-pipeline types: particle word layout, feeder FSM encoding and
// the drain interval the scatterer needs to retire its last particle.
package defs;

    typedef struct packed {
        logic [15:0] pos;
        logic [15:0] vel;
        logic [15:0] wgt;
    } particle_t;

    localparam int PSIZE = $bits(particle_t);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} feed_state_t;

    // Scatterer pipeline depth plus accumulator/BRAM write-back.
    localparam int FEED_DRAIN_DEFAULT = 32;

endpackage

// File: rtl/particle_feeder_valid_delay.sv
// DEPTH-stage valid shift register; tracks issued reads through the memory latency.
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/particle_feeder.sv
// Streams particles from particle memory to the scatterer, then holds off `done`
// until the scatterer has had time to retire the last particle.
module particle_feeder
    import defs::*;
#(
    parameter int NPART_W      = 16,
    parameter int RD_LAT       = 2,
    parameter int ISSUE_GAP    = 1,
    parameter int DRAIN_CYCLES = FEED_DRAIN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NPART_W-1:0] num_particles,
    input  logic               pause,
    output logic               mem_ren,
    output logic [NPART_W-1:0] mem_raddr,
    input  logic [PSIZE-1:0]   mem_rdata,
    output logic               valid_scatter,
    output particle_t          particle_out,
    output logic               busy,
    output logic               done
);

    // Drain counter reaches zero exactly RD_LAT+1+DRAIN_CYCLES cycles after the last issue.
    localparam int DRAIN_LOAD = RD_LAT + DRAIN_CYCLES;
    localparam int DW         = $clog2(DRAIN_LOAD + 1);
    localparam int GW         = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    feed_state_t        state_q, state_d;
    logic [NPART_W-1:0] count_q, count_d;
    logic [NPART_W-1:0] addr_q, addr_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic               valid_scatter_q, valid_scatter_d;
    particle_t          particle_out_q, particle_out_d;
    logic               issue;
    logic               rd_vld;

    valid_delay #(.DEPTH(RD_LAT)) u_rd_vld (
        .clk  (clk),
        .rst  (rst),
        .din  (issue),
        .dout (rd_vld)
    );

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        addr_d          = addr_q;
        gap_d           = gap_q;
        drain_d         = drain_q;
        issue           = 1'b0;
        valid_scatter_d = rd_vld;
        particle_out_d  = rd_vld ? particle_t'(mem_rdata) : particle_out_q;

        if (gap_q != '0) gap_d = gap_q - GW'(1);

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    count_d = num_particles;
                    addr_d  = '0;
                    gap_d   = '0;
                    state_d = (num_particles == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (!pause && gap_q == '0) begin
                    issue  = 1'b1;
                    addr_d = addr_q + NPART_W'(1);
                    gap_d  = GW'(ISSUE_GAP - 1);
                    // Compare against count-1 so a full 2^NPART_W-1 pass never wraps.
                    if (addr_q == count_q - NPART_W'(1)) begin
                        state_d = DRAIN;
                        drain_d = DW'(DRAIN_LOAD);
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q - DW'(1);
                if (drain_q == DW'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            count_q         <= '0;
            addr_q          <= '0;
            gap_q           <= '0;
            drain_q         <= '0;
            valid_scatter_q <= 1'b0;
            particle_out_q  <= '0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            addr_q          <= addr_d;
            gap_q           <= gap_d;
            drain_q         <= drain_d;
            valid_scatter_q <= valid_scatter_d;
            particle_out_q  <= particle_out_d;
        end
    end

    assign mem_ren       = issue;
    assign mem_raddr     = issue ? addr_q : '0;
    assign valid_scatter = valid_scatter_q;
    assign particle_out  = particle_out_q;
    assign busy          = (state_q == STREAM) || (state_q == DRAIN);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_particle_feeder.sv
// Scoreboard bench: two feeders (gap 1 / gap 3) driven with random passes and
// checked against a schedule computed from the issue/latency/drain rules.
module tb_particle_feeder;
    import defs::*;

    localparam int RDL  = 2;
    localparam int GAP0 = 1;
    localparam int GAP1 = 3;
    localparam int DRN0 = 32;
    localparam int DRN1 = 5;
    localparam int PZN  = 512;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } ev_t;

    logic             clk, rst;
    logic             start_s [2];
    logic [15:0]      num_s   [2];
    logic             pause_s [2];
    logic             ren_s   [2];
    logic [15:0]      raddr_s [2];
    logic             vs_s    [2];
    particle_t        pout_s  [2];
    logic             busy_s  [2];
    logic             done_s  [2];
    logic [PSIZE-1:0] st0     [2];
    logic [PSIZE-1:0] st1     [2];
    logic [PSIZE-1:0] mem     [2][64];

    ev_t iq [2][$];
    ev_t vq [2][$];
    ev_t e;
    bit  pz [PZN];
    int  cyc, s_cyc, done_c, cur_n, mis;
    int  checks, passes;

    particle_feeder #(.NPART_W(16), .RD_LAT(RDL), .ISSUE_GAP(GAP0), .DRAIN_CYCLES(DRN0)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .num_particles(num_s[0]), .pause(pause_s[0]),
        .mem_ren(ren_s[0]), .mem_raddr(raddr_s[0]), .mem_rdata(st1[0]),
        .valid_scatter(vs_s[0]), .particle_out(pout_s[0]), .busy(busy_s[0]), .done(done_s[0]));

    particle_feeder #(.NPART_W(16), .RD_LAT(RDL), .ISSUE_GAP(GAP1), .DRAIN_CYCLES(DRN1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .num_particles(num_s[1]), .pause(pause_s[1]),
        .mem_ren(ren_s[1]), .mem_raddr(raddr_s[1]), .mem_rdata(st1[1]),
        .valid_scatter(vs_s[1]), .particle_out(pout_s[1]), .busy(busy_s[1]), .done(done_s[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data valid RDL cycles after the read, garbage otherwise.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            st0[k] <= ren_s[k] ? mem[k][raddr_s[k][5:0]] : PSIZE'({$urandom, $urandom});
            st1[k] <= st0[k];
        end
    end

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (ren_s[k]) begin
                    if (iq[k].size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_ren inst%0d cycle %0d: got addr %0h expected no read", k, cyc, raddr_s[k]);
                    end else begin
                        e = iq[k].pop_front();
                        chk("ren_cycle", k, 64'(cyc), 64'(e.cyc));
                        chk("ren_addr", k, 64'(raddr_s[k]), e.val);
                    end
                end
                if (vs_s[k]) begin
                    if (vq[k].size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_valid inst%0d cycle %0d: got %0h expected no pulse", k, cyc, pout_s[k]);
                    end else begin
                        e = vq[k].pop_front();
                        chk("vs_cycle", k, 64'(cyc), 64'(e.cyc));
                        chk("vs_data", k, 64'(pout_s[k]), e.val);
                    end
                end
            end
        end
    end

    function automatic bit pz_at(input int r);
        return (r >= 0 && r < PZN) ? pz[r] : 1'b0;
    endfunction

    // Start a pass this cycle and enqueue the full expected schedule.
    task automatic launch(input int k, input int n, input int pmode, input bit fixed);
        int t, ok, last, gap, drn;
        gap = (k == 0) ? GAP0 : GAP1;
        drn = (k == 0) ? DRN0 : DRN1;
        for (int r = 0; r < PZN; r++)
            pz[r] = (pmode == 1) ? ($urandom_range(3) == 0) : (pmode == 2 && r >= 5 && r <= 9);
        for (int a = 0; a < 64; a++) mem[k][a] = PSIZE'({$urandom, $urandom});
        if (fixed) begin
            mem[k][0] = PSIZE'(48'hA);
            mem[k][1] = PSIZE'(48'hB);
            mem[k][2] = PSIZE'(48'hC);
        end
        s_cyc = cyc;
        cur_n = n;
        start_s[k] = 1'b1;
        num_s[k]   = 16'(n);
        pause_s[k] = pz[0];
        ok   = s_cyc + 1;
        last = s_cyc;
        for (int i = 0; i < n; i++) begin
            t = ok;
            while (pz_at(t - s_cyc)) t++;
            iq[k].push_back('{cyc: t, val: 64'(i)});
            vq[k].push_back('{cyc: t + RDL + 1, val: 64'(mem[k][i])});
            ok   = t + gap;
            last = t;
        end
        done_c = (n == 0) ? s_cyc + 1 : last + RDL + 1 + drn;
    endtask

    task automatic drive_cycle(input int k, input bit restart);
        @(posedge clk); #1;
        start_s[k] = restart;
        num_s[k]   = restart ? 16'd10 : 16'(cur_n);
        pause_s[k] = pz_at(cyc - s_cyc);
        @(negedge clk);
        if (done_s[k] !== (cyc >= done_c) || busy_s[k] !== (cur_n != 0 && cyc < done_c)) mis++;
    endtask

    task automatic run_pass(input int k, input int n, input int pmode, input bit fixed,
                            input int restart_rel, input string nm);
        @(posedge clk); #1;
        launch(k, n, pmode, fixed);
        mis = 0;
        while (cyc < done_c + 3)
            drive_cycle(k, restart_rel != 0 && cyc + 1 == s_cyc + restart_rel);
        pause_s[k] = 1'b0;
        chk({nm, "_done_busy"}, k, 64'(mis), 64'd0);
        chk({nm, "_reads_left"}, k, 64'(iq[k].size()), 64'd0);
        chk({nm, "_valids_left"}, k, 64'(vq[k].size()), 64'd0);
    endtask

    initial begin
        int act;
        checks = 0; passes = 0; cyc = 0; mis = 0;
        s_cyc = 0; done_c = 0; cur_n = 0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; num_s[k] = '0; pause_s[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_ctrl", k, 64'({ren_s[k], vs_s[k], busy_s[k], done_s[k], raddr_s[k]}), 64'd0);
            chk("reset_pout", k, 64'(pout_s[k]), 64'd0);
        end
        @(posedge clk); #2;
        rst = 1'b0;

        run_pass(0, 0, 0, 0, 0, "zero_idle");
        run_pass(0, 3, 0, 1, 0, "basic");
        run_pass(0, 0, 0, 0, 0, "zero_done");
        run_pass(1, 4, 2, 0, 0, "gap_pause");
        run_pass(0, 2, 0, 0, 10, "restart_drain");
        for (int j = 0; j < 6; j++) run_pass(j % 2, int'($urandom_range(20, 1)), 1, 0, 0, "rand");

        // Reset between edges after two of five reads have issued.
        @(posedge clk); #1;
        launch(0, 5, 0, 0);
        drive_cycle(0, 1'b0);
        drive_cycle(0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_ctrl", 0, 64'({ren_s[0], vs_s[0], busy_s[0], done_s[0], raddr_s[0]}), 64'd0);
        chk("midrst_pout", 0, 64'(pout_s[0]), 64'd0);
        iq[0].delete();
        vq[0].delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        act = 0;
        repeat (12) begin
            @(negedge clk);
            act += int'(ren_s[0]) + int'(vs_s[0]);
        end
        chk("post_rst_quiet", 0, 64'(act), 64'd0);
        run_pass(0, 1, 0, 0, 0, "post_rst");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
